// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV32M multiply/divide sequencer for the execute stage.
// An iterative shift-add multiplier and a restoring divider each run XLEN
// iterations. busy_o stalls the pipeline while an operation is in flight.
// Divide by zero and signed overflow finish in one cycle with a preloaded result.
// Optional feature: define MDU_FAST_MUL_EN to compute MUL/MULH/MULHSU/MULHU with a
// combinational multiplier in IDLE, which finishes in one cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             request, accepted only in IDLE and only when kill_i is low
//   funct3_i            M-extension op select
//   op_a_i, op_b_i      rs1/rs2 operands, sampled on the accept edge
//   kill_i              pipeline flush, aborts the current operation
//   busy_o              high while not IDLE
//   done_o              one-cycle result-valid pulse
//   result_o            registered result, held until the next done_o
module mdu_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      fn;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] hi, lo, mcand;
    logic [XLEN-1:0] result_q;
    logic            busy_q, done_q;

    logic              is_div, a_sgn, b_sgn, sa_in, sb_in;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic              fast_hit;
    logic [XLEN-1:0]   fast_res;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    // Operand decode, magnitudes and single-cycle special cases
    always_comb begin
        is_div  = funct3_i[2];
        a_sgn   = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                  (funct3_i == 3'b100) || (funct3_i == 3'b110);
        b_sgn   = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        sa_in   = a_sgn & op_a_i[XLEN-1];
        sb_in   = b_sgn & op_b_i[XLEN-1];
        mag_a   = sa_in ? -op_a_i : op_a_i;
        mag_b   = sb_in ? -op_b_i : op_b_i;
        special     = 1'b0;
        special_res = '0;
        if (is_div && (op_b_i == '0)) begin
            special     = 1'b1;
            special_res = funct3_i[1] ? op_a_i : '1;
        end else if (is_div && !funct3_i[0] && (op_a_i == INT_MIN) && (op_b_i == '1)) begin
            special     = 1'b1;
            special_res = funct3_i[1] ? '0 : op_a_i;
        end
    end

    // Optional single-cycle multiplier
    always_comb begin
`ifdef MDU_FAST_MUL_EN
        fast_prod = (2*XLEN)'((2*XLEN+2)'($signed({sa_in, op_a_i})) *
                              (2*XLEN+2)'($signed({sb_in, op_b_i})));
        fast_hit  = !is_div;
        fast_res  = (funct3_i[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
        fast_hit  = 1'b0;
        fast_res  = '0;
`endif
    end

    // One iteration step: hi/lo hold product or remainder/quotient, mcand the other operand
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, mcand});
        rem_sub   = XLEN'(div_shift - {1'b0, mcand});
    end

    // Sign correction and result selection
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -{hi, lo} : {hi, lo};
        quo_fix  = (sign_a ^ sign_b) ? -lo : lo;
        rem_fix  = sign_a ? -hi : hi;
        case (fn)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            fn       <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !kill_i) begin
                        fn     <= funct3_i;
                        sign_a <= sa_in;
                        sign_b <= sb_in;
                        busy_q <= 1'b1;
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else if (fast_hit) begin
                            result_q <= fast_res;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            hi    <= '0;
                            cnt   <= CW'(XLEN-1);
                            state <= CALC;
                            // Divide: lo=dividend shifts out into the remainder
                            // Multiply: lo=multiplier shifts out as product bits shift in
                            lo    <= is_div ? mag_a : mag_b;
                            mcand <= is_div ? mag_b : mag_a;
                        end
                    end
                end
                CALC: begin
                    if (kill_i) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        if (fn[2]) begin
                            hi <= div_ge ? rem_sub : div_shift[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], div_ge};
                        end else begin
                            hi <= mul_sum[XLEN:1];
                            lo <= {mul_sum[0], lo[XLEN-1:1]};
                        end
                        cnt <= cnt - CW'(1);
                        if (cnt == '0) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (kill_i) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    // A flush arriving in the DONE cycle itself must still suppress the pulse,
    // so the registered flag is gated by kill_i.
    assign done_o   = done_q & ~kill_i;
    assign result_o = result_q;

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide instructions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the ALU in the execute stage. The main decoder raises start_i for R-type, funct7=0000001 instructions.
- Runs an iterative shift-add multiplier or a restoring divider over XLEN cycles, holding busy_o to stall the pipeline.
- Returns a registered result with a one-cycle done_o pulse.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start_i  input  1  request; accepted only in IDLE.
- funct3_i  input  3  M-extension op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_i  input  XLEN  rs1 value; sampled on the accept edge only.
- op_b_i  input  XLEN  rs2 value; sampled on the accept edge only.
- kill_i  input  1  pipeline flush; aborts the current operation.
- busy_o  output  1  high whenever state != IDLE (pipeline stall).
- done_o  output  1  one-cycle pulse; result_o valid.
- result_o  output  XLEN  registered result; held until the next done_o.

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset (any time, including mid-operation): state=IDLE, busy_o=0, done_o=0, result_o=0, counter=0, internal operand/accumulator registers=0.
- States: IDLE, CALC, FIX, DONE.
  - IDLE: on start_i=1, latch funct3, operands and operand signs.
    - Special case: go to DONE with the result preloaded.
    - Otherwise: go to CALC with counter=XLEN-1.
  - CALC: one iteration per cycle.
    - Multiply: add multiplicand if the LSB of the multiplier is set, then shift the 2*XLEN product right.
    - Divide: shift the remainder/quotient left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
    - Operands are converted to magnitudes before iterating (signed ops only).
    - Counter decrements each cycle; at 0 go to FIX.
  - FIX: apply sign correction.
    - Product negated if sign_a XOR sign_b (MULHSU: sign_a only).
    - Quotient negated if signs differ; remainder takes the sign of the dividend.
    - Select low/high half or quotient/remainder into result_o. Go to DONE.
  - DONE: done_o=1 for exactly this cycle. Go to IDLE.
- Latency: start accepted in cycle 0 -> CALC cycles 1..XLEN, FIX cycle XLEN+1, done_o in cycle XLEN+2 (34 for XLEN=32).
- Special cases (resolved in IDLE, done_o in cycle 1):
  - DIV/DIVU with op_b=0: quotient all ones.
  - REM/REMU with op_b=0: remainder = op_a.
  - DIV with op_a=-2^(XLEN-1), op_b=-1: result = op_a; REM result = 0.
- Handshake:
  - start_i is ignored while busy_o=1; there is no queueing.
  - start_i in the DONE cycle is also ignored.
  - Back-to-back: a new start is accepted the cycle after done_o.
- kill_i:
  - In CALC/FIX/DONE: next state IDLE, done_o suppressed in that cycle, result_o unchanged.
  - kill_i with start_i in IDLE: kill wins; no accept.
- result_o changes only on the edge entering DONE.
- Arithmetic is modulo 2^XLEN (low half) or 2^(2*XLEN) (product), with no overflow flags.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: funct3 000-011 are computed with a combinational 2*XLEN signed/unsigned multiplier in IDLE and go directly to DONE (done_o in cycle 1). Divide path unchanged.
- Undefined: all multiplies use the iterative CALC/FIX path (done_o in cycle XLEN+2). No combinational multiplier is instantiated.

Test Plan:
- MUL: op_a=7, op_b=-3, start cycle 0 -> busy_o cycles 1..34 (fast: done cycle 1), done_o cycle 34, result_o=0xFFFFFFEB.
- MULH / MULHU / MULHSU: op_a=op_b=0x80000000.
  - MULH -> 0x40000000.
  - MULHU -> 0x40000000.
  - MULHSU -> 0xC0000000.
- DIV/REM: op_a=-20, op_b=6.
  - DIV -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFE (-2).
  - DIVU of 20/6 -> 3; REMU -> 2.
- Special cases, done_o in cycle 1:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- Handshake:
  - start_i held high during DIV -> only one done_o; second op accepted the cycle after done_o.
  - kill_i in cycle 10 -> busy_o low cycle 11, no done_o, result_o keeps its previous value.
- Reset: rst_n low asynchronously in cycle 15 of a DIV -> busy_o, done_o, result_o=0 immediately. Fresh MUL 3*4 after release -> 12.
